// File: rtl/fir_pkg.sv
// Definitions shared across the FIR sample path: default sample width and
// the read-controller state encoding.
package fir_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/fir_skid_buf.sv
// Two-entry register buffer between the FIFO pop and the FIR stream.
// The head entry is visible combinationally; push and pop may coincide.
module fir_skid_buf
  import fir_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic [1:0]   r_count;
  logic         w_wr_ptr;

  // Write slot is head+count modulo 2; a push never arrives with count=2.
  assign w_wr_ptr = r_head ^ r_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_mem[w_wr_ptr] <= i_push_data;
      if (i_pop) r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/fifo_sample_reader.sv
// Read-side controller for the filter sample FIFO: pops samples into a
// 2-entry buffer, streams them to the FIR with frame tagging and stops only on frame edges.
//
// state  | meaning
// IDLE   | stopped; no pops, underruns not counted
// RUN    | streaming; en=0 leads to FINISH (mid-frame) or DRAIN (on boundary)
// FINISH | popping the rest of the current frame, en ignored
// DRAIN  | no pops; emptying the buffer to the FIR, then IDLE
module fifo_sample_reader
  import fir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_pop_idx;
  logic [IDX_W-1:0]  w_pop_idx_next;
  logic [CNT_W-1:0]  r_underrun_cnt;
  logic [1:0]        w_buf_count;
  logic [DATA_W:0]   w_buf_head;
  logic              w_pop;
  logic              w_pop_last;
  logic              w_xfer;
  logic              w_active;
  logic              w_starved;
  logic              w_buf_empty_next;

  assign w_pop      = fifo_rd_en;
  assign w_pop_last = (r_pop_idx == LAST_IDX);
  assign out_valid  = (w_buf_count != 2'd0);
  assign w_xfer     = out_valid & out_ready;
  assign w_buf_empty_next = (w_buf_count == 2'd0) ||
                            ((w_buf_count == 2'd1) && w_xfer);

  always_comb begin
    w_pop_idx_next = r_pop_idx;
    if (w_pop) w_pop_idx_next = w_pop_last ? '0 : r_pop_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // The stop decision uses the post-pop index so a pop taken in the same
  // cycle as the stop is always followed by the rest of its frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (en) w_state_next = RUN;
      RUN:    if (!en) w_state_next = (w_pop_idx_next != '0) ? FINISH : DRAIN;
      FINISH: if (w_pop && w_pop_last) w_state_next = DRAIN;
      DRAIN:  if (w_buf_empty_next) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_active   = (r_state == RUN) || (r_state == FINISH);
    fifo_rd_en = w_active & ~fifo_empty & (w_buf_count < 2'd2);
    busy       = (r_state != IDLE);
    w_starved  = w_active & out_ready & ~out_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_idx      <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_pop_idx <= w_pop_idx_next;
      if (w_starved && (r_underrun_cnt != CNT_MAX))
        r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  fir_skid_buf #(.W(DATA_W + 1)) u_skid_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_pop),
    .i_push_data ({fifo_rd_data, w_pop_last}),
    .i_pop       (w_xfer),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count)
  );

  assign out_data     = w_buf_head[DATA_W:1];
  assign out_last     = w_buf_head[0];
  assign underrun_cnt = r_underrun_cnt;

endmodule
